// File: rtl/sum_uart_tx.sv
// UART 8N1 transmitter fed by a small byte FIFO; drains adder results onto one pin.
// Baud rate is clk / CLKS_PER_BIT. Bytes go out LSB first, in push order.
module sum_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int unsigned CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned COUNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]   BAUD_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [COUNT_W-1:0] count_q;

  logic push;
  logic pop;
  logic baud_done;

  // in_ready depends only on the registered count, so a full FIFO refuses
  // a push even when the FSM pops in the same cycle.
  assign in_ready   = (count_q != FULL_COUNT);
  assign push       = in_valid && in_ready;
  assign baud_done  = (baud_q == BAUD_LAST);

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

  // NOTE: every signal driven here gets its hold value first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    pop     = 1'b0;

    // With ena low everything above simply holds, freezing the frame in place.
    if (ena) begin
      case (state_q)
        IDLE: begin
          tx_d   = 1'b1;
          busy_d = 1'b0;
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            baud_d  = '0;
            bit_d   = '0;
            state_d = START;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
          end
        end
        START: begin
          if (baud_done) begin
            baud_d  = '0;
            state_d = DATA;
            tx_d    = shift_q[0];
          end else begin
            baud_d  = baud_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_d = '0;
            if (bit_q == 3'd7) begin
              state_d = STOP;
              tx_d    = 1'b1;
            end else begin
              bit_d   = bit_q + 3'd1;
              shift_d = {1'b0, shift_q[7:1]};
              tx_d    = shift_q[1];
            end
          end else begin
            baud_d = baud_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_d  = '0;
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end else begin
            baud_d  = baud_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + COUNT_W'(1);
        2'b01:   count_q <= count_q - COUNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only read after a push
  // has written them, and the pointers/count are what reset flushes.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: doc/sum_uart_tx.md
# sum_uart_tx

Serial output stage that sits directly downstream of the 8-bit adder on the chip. It buffers accepted sum bytes in a small FIFO and transmits each one on a single pin as a UART 8N1 frame, LSB first. This lets an external host read every result over one wire. The baud rate is a fixed integer divide of the chip clock.

## Interface
Parameters:
- CLKS_PER_BIT, default 16: clock cycles per UART bit. Legal range is 2..65535.
- FIFO_DEPTH, default 4: number of byte entries. Must be a power of 2, at least 2.

Ports:
- clk, input, 1: the only clock. All logic is on the rising edge.
- rst_n, input, 1: reset, synchronous, active-low, sampled on the rising edge of clk.
- ena, input, 1: run enable. When 0, the transmitter freezes; the FIFO still accepts bytes.
- in_data, input, 8: sum byte from the adder.
- in_valid, input, 1: in_data is valid this cycle.
- in_ready, output, 1: the FIFO can accept a byte. Equals !full, driven from registered state.
- tx, output, 1: UART line. Idle level is high. Registered.
- busy, output, 1: high while a frame is in flight (any state except IDLE). Registered.
- fifo_count, output, $clog2(FIFO_DEPTH)+1: number of bytes held. Registered.

## Operation
- Push rule: a byte is written when in_valid && in_ready at a rising edge.
  - It goes to the write pointer, and the pointer and count update at that edge.
  - When the FIFO is full, in_ready is 0. The push is refused even if a pop happens in the same cycle.
  - A refused byte is not stored; the upstream stage must hold it.
- Pop rule: the FSM pops the head entry when it leaves IDLE.
- Simultaneous push and pop in one cycle: count is unchanged, both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If ena=1 and fifo_count>0 at an edge: load the head into the shift register, pop, clear the baud counter and bit index, go to START.
- START:
  - tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx = shift[0]. Each bit is held CLKS_PER_BIT cycles, then the register shifts right.
  - After bit index 7 completes, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and advances the bit when it reaches CLKS_PER_BIT-1.
  - Width is $clog2(CLKS_PER_BIT).
  - Counter arithmetic never overflows past the terminal count.
- ena=0 behaviour:
  - The baud counter, FSM state and shift register hold, and tx holds its current level.
  - The frame resumes exactly where it stopped once ena=1.
- Bytes are transmitted strictly in push order.

## Timing
- Reset values: tx=1, busy=0, fifo_count=0, in_ready=1, FSM=IDLE, pointers=0.
- Reset mid-frame:
  - tx returns high on the first edge with rst_n=0.
  - The in-flight frame is aborted and the FIFO is flushed.
  - Pushes are ignored while rst_n=0.
- Latency when idle and empty:
  - A push accepted at edge N gives fifo_count=1 after N.
  - The FSM loads at edge N+1; tx=0 and busy=1 after edge N+1.
  - This is a 2-edge latency from the accepting cycle to the start bit.
- Frame length: 10×CLKS_PER_BIT cycles, from the falling start edge to the end of the stop bit.
- Back-to-back frames: IDLE lasts exactly 1 cycle between frames, so the stop bit plus 1 extra high cycle.
  - Frame period is 10×CLKS_PER_BIT+1 cycles.
- in_ready rises on the edge after a pop from a full FIFO.
- busy falls on the edge the FSM enters IDLE.

## Test plan
- Single byte, CLKS_PER_BIT=4: push 0xA5 at edge 0.
  - tx is low during edges 2..5.
  - Then bits 1,0,1,0,0,1,0,1 follow, 4 cycles each.
  - Then high for 4 cycles. busy is high for 40 cycles, and fifo_count returns to 0 after edge 1.
- Fill with ena=0: push 0x11,0x22,0x33,0x44,0x55 on consecutive cycles.
  - The first 4 are accepted, fifo_count=4, in_ready=0, and 0x55 is refused.
  - After ena=1, frames for 0x11..0x44 appear in order, each separated by 1 idle cycle (41-cycle period at CLKS_PER_BIT=4).
  - in_ready=1 on the edge after the first pop.
- Pause mid-frame: drop ena for 7 cycles during DATA bit 3 of 0x0F.
  - tx holds its level for the 7 cycles, and the frame is 7 cycles longer.
  - The decoded byte is still 0x0F.
- Reset mid-frame: assert rst_n=0 during DATA with 3 bytes queued.
  - On the next edge tx=1, busy=0 and fifo_count=0.
  - After release, nothing is transmitted until a new push.
- Push/pop collision: with fifo_count=2, push at the same edge the FSM leaves IDLE.
  - fifo_count stays 2, and output order is preserved across the pointer wrap (run ≥6 bytes through a 4-deep FIFO).
